// File: rtl/game_pkg.sv
// Shared definitions for the game sequencing stage: state encodings (also used
// by the LCD driver's gameStr indexing), display widths and button indices.
package game_pkg;

    localparam int TIME_W  = 7;
    localparam int POINT_W = 7;

    localparam int BTN_START = 0;
    localparam int BTN_HIT   = 1;
    localparam int BTN_MISS  = 2;
    localparam int BTN_N     = 3;

    typedef enum logic [1:0] {
        START     = 2'd0,
        GAMING    = 2'd1,
        GAME_OVER = 2'd2
    } game_state_t;

endpackage

// File: rtl/game_ctrl_if.sv
// Button requests in, LCD/LED-facing game status out. The master side is the
// game controller; the slave side is the board/LCD environment.
interface game_ctrl_if;
    import game_pkg::*;

    logic               start_btn;
    logic               hit_btn;
    logic               miss_btn;
    logic [1:0]         gameState;
    logic [TIME_W-1:0]  timeNum;
    logic [POINT_W-1:0] point;
    logic               sec_tick;
    logic [POINT_W-1:0] hiscore;

    modport master (
        input  start_btn, hit_btn, miss_btn,
        output gameState, timeNum, point, sec_tick, hiscore
    );

    modport slave (
        output start_btn, hit_btn, miss_btn,
        input  gameState, timeNum, point, sec_tick, hiscore
    );

endinterface

// File: rtl/game_ctrl_btn_sync_edge.sv
// Two-flop synchroniser for an asynchronous button level, followed by an edge
// flop; pulse is high for exactly one Clk cycle per press, however long held.
module btn_sync_edge (
    input  logic Clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    logic sync1_reg;
    logic sync2_reg;
    logic sync3_reg;

    always_ff @(posedge Clk) begin
        if (rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            sync3_reg <= 1'b0;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync1_reg;
            sync3_reg <= sync2_reg;
        end
    end

    assign pulse = sync2_reg & ~sync3_reg;

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: START/GAMING/GAME_OVER FSM, 1 Hz countdown and score.
// Define HISCORE_EN to keep a best-score register; otherwise hiscore reads 0.
module game_ctrl
    import game_pkg::*;
#(
    parameter int CLK_HZ    = 50000000,
    parameter int GAME_SEC  = 30,
    parameter int MAX_POINT = 99
) (
    input  logic        Clk,
    input  logic        rst,
    game_ctrl_if.master bus
);

    localparam int DIV_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [DIV_W-1:0]   DIV_MAX   = DIV_W'(CLK_HZ - 1);
    localparam logic [TIME_W-1:0]  TIME_INIT = TIME_W'(GAME_SEC);
    localparam logic [POINT_W-1:0] POINT_MAX = POINT_W'(MAX_POINT);

    logic [BTN_N-1:0] btn_raw;
    logic [BTN_N-1:0] btn_ev;

    assign btn_raw[BTN_START] = bus.start_btn;
    assign btn_raw[BTN_HIT]   = bus.hit_btn;
    assign btn_raw[BTN_MISS]  = bus.miss_btn;

    genvar gi;
    generate
        for (gi = 0; gi < BTN_N; gi++) begin : g_btn
            btn_sync_edge u_sync (
                .Clk   (Clk),
                .rst   (rst),
                .btn   (btn_raw[gi]),
                .pulse (btn_ev[gi])
            );
        end
    endgenerate

    logic start_ev;
    logic hit_ev;
    logic miss_ev;
    assign start_ev = btn_ev[BTN_START];
    assign hit_ev   = btn_ev[BTN_HIT];
    assign miss_ev  = btn_ev[BTN_MISS];

    game_state_t        state_reg,  state_next;
    logic [TIME_W-1:0]  time_reg,   time_next;
    logic [POINT_W-1:0] point_reg,  point_next;
    logic [DIV_W-1:0]   div_reg,    div_next;
    logic               tick;
    logic               wrap;

    assign wrap = (div_reg == DIV_MAX);

    always_ff @(posedge Clk) begin
        if (rst) begin
            state_reg <= START;
            time_reg  <= TIME_INIT;
            point_reg <= '0;
            div_reg   <= '0;
        end else begin
            state_reg <= state_next;
            time_reg  <= time_next;
            point_reg <= point_next;
            div_reg   <= div_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        time_next  = time_reg;
        point_next = point_reg;
        div_next   = div_reg;
        tick       = 1'b0;
        case (state_reg)
            START: begin
                div_next = '0;
                if (start_ev) begin
                    state_next = GAMING;
                    time_next  = TIME_INIT;
                    point_next = '0;
                end
            end
            GAMING: begin
                if (wrap) begin
                    div_next = '0;
                    tick     = 1'b1;
                    // The last second expiring ends the game on the same edge.
                    if (time_reg <= TIME_W'(1)) begin
                        time_next  = '0;
                        state_next = GAME_OVER;
                    end else begin
                        time_next = time_reg - 1'b1;
                    end
                end else begin
                    div_next = div_reg + 1'b1;
                end
                if (hit_ev && !miss_ev && (point_reg < POINT_MAX)) begin
                    point_next = point_reg + 1'b1;
                end else if (miss_ev && !hit_ev && (point_reg != '0)) begin
                    point_next = point_reg - 1'b1;
                end
            end
            GAME_OVER: begin
                div_next  = '0;
                time_next = '0;
                if (start_ev) begin
                    state_next = START;
                    time_next  = TIME_INIT;
                    point_next = '0;
                end
            end
            default: begin
                state_next = START;
                time_next  = TIME_INIT;
                point_next = '0;
                div_next   = '0;
            end
        endcase
    end

    assign bus.gameState = state_reg;
    assign bus.timeNum   = time_reg;
    assign bus.point     = point_reg;
    assign bus.sec_tick  = tick;

`ifdef HISCORE_EN
    logic [POINT_W-1:0] hiscore_reg;
    logic               was_over_reg;
    logic               over_first;

    assign over_first = (state_reg == GAME_OVER) && !was_over_reg;

    always_ff @(posedge Clk) begin
        if (rst) begin
            hiscore_reg  <= '0;
            was_over_reg <= 1'b0;
        end else begin
            was_over_reg <= (state_reg == GAME_OVER);
            if (over_first && (point_reg > hiscore_reg)) begin
                hiscore_reg <= point_reg;
            end
        end
    end

    assign bus.hiscore = hiscore_reg;
`else
    assign bus.hiscore = '0;
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: two instances (MAX_POINT 99 and 4) share the
// same button stimulus, with CLK_HZ = 10 and GAME_SEC = 3.
module tb_game_ctrl;
    import game_pkg::*;

    logic Clk = 1'b0;
    logic rst = 1'b1;
    always #5 Clk = ~Clk;

    game_ctrl_if bus();
    game_ctrl_if bus_sat();

    assign bus_sat.start_btn = bus.start_btn;
    assign bus_sat.hit_btn   = bus.hit_btn;
    assign bus_sat.miss_btn  = bus.miss_btn;

    game_ctrl #(.CLK_HZ(10), .GAME_SEC(3), .MAX_POINT(99)) dut (
        .Clk (Clk),
        .rst (rst),
        .bus (bus)
    );

    game_ctrl #(.CLK_HZ(10), .GAME_SEC(3), .MAX_POINT(4)) dut_sat (
        .Clk (Clk),
        .rst (rst),
        .bus (bus_sat)
    );

    int n_cmp = 0;
    int n_err = 0;
    int exp_hi = 0;
    int exp_hi_sat = 0;
    int ticks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    // which: 0 start, 1 hit, 2 miss, 3 hit+miss together
    task automatic set_btn(input int which, input logic v);
        case (which)
            0: bus.start_btn = v;
            1: bus.hit_btn   = v;
            2: bus.miss_btn  = v;
            default: begin
                bus.hit_btn  = v;
                bus.miss_btn = v;
            end
        endcase
    endtask

    task automatic pulse(input int which);
        set_btn(which, 1'b1);
        step(1);
        set_btn(which, 1'b0);
        step(1);
    endtask

    task automatic game_over_score(input int p, input int p_sat);
`ifdef HISCORE_EN
        if (p > exp_hi) exp_hi = p;
        if (p_sat > exp_hi_sat) exp_hi_sat = p_sat;
`endif
        step(1);
        chk("hiscore", bus.hiscore, exp_hi);
        chk("hiscore_sat", bus_sat.hiscore, exp_hi_sat);
        $display("game over: point %0d/%0d hiscore %0d/%0d", bus.point, bus_sat.point,
                 bus.hiscore, bus_sat.hiscore);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start_btn = 1'b0;
        bus.hit_btn   = 1'b0;
        bus.miss_btn  = 1'b0;
        rst = 1'b1;
        step(2);
        chk("rst_state", bus.gameState, 0);
        chk("rst_time", bus.timeNum, 3);
        chk("rst_point", bus.point, 0);
        chk("rst_tick", bus.sec_tick, 0);
        chk("rst_hiscore", bus.hiscore, 0);
        rst = 1'b0;
        step(1);
        $display("reset released");

        // Hit in START is ignored.
        pulse(1);
        step(1);
        chk("start_hit_ignored", bus.point, 0);
        chk("start_stays", bus.gameState, 0);

        // Game 1: timer walk.
        pulse(0);
        chk("start_latency_early", bus.gameState, 0);
        step(1);
        chk("start_latency", bus.gameState, 1);
        chk("game1_time0", bus.timeNum, 3);
        $display("game 1 started");
        for (int i = 1; i <= 30; i++) begin
            step(1);
            ticks += int'(bus.sec_tick);
            if (i == 9)  chk("tick_first", bus.sec_tick, 1);
            if (i == 10) chk("time_2", bus.timeNum, 2);
            if (i == 20) chk("time_1", bus.timeNum, 1);
            if (i == 29) chk("last_wrap_state", bus.gameState, 1);
            if (i == 30) begin
                chk("time_0", bus.timeNum, 0);
                chk("over_same_edge", bus.gameState, 2);
            end
        end
        chk("tick_count", ticks, 3);
        ticks = 0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            ticks += int'(bus.sec_tick);
        end
        chk("over_no_tick", ticks, 0);
        chk("over_time_held", bus.timeNum, 0);
        game_over_score(0, 0);

        // Restart from GAME_OVER to START.
        pulse(0);
        step(1);
        chk("restart_state", bus.gameState, 0);
        chk("restart_time", bus.timeNum, 3);
        chk("restart_point", bus.point, 0);

        // Game 2: hits/misses and floor at 0.
        pulse(0);
        step(1);
        chk("game2_state", bus.gameState, 1);
        for (int i = 0; i < 5; i++) pulse(1);
        for (int i = 0; i < 2; i++) pulse(2);
        step(1);
        chk("point_5h2m", bus.point, 3);
        chk("sat_5h2m", bus_sat.point, 2);
        $display("game 2 after 5 hits 2 misses: %0d/%0d", bus.point, bus_sat.point);
        for (int i = 0; i < 4; i++) pulse(2);
        step(1);
        chk("point_floor", bus.point, 0);
        chk("sat_floor", bus_sat.point, 0);
        step(6);
        chk("game2_over", bus.gameState, 2);
        game_over_score(0, 0);

        // Game 3: saturation, simultaneous hit+miss, hit on final wrap.
        pulse(0);
        step(1);
        pulse(0);
        step(1);
        chk("game3_state", bus.gameState, 1);
        for (int i = 0; i < 6; i++) pulse(1);
        step(1);
        chk("point_6h", bus.point, 6);
        chk("sat_6h", bus_sat.point, 4);
        pulse(3);
        step(1);
        chk("point_both", bus.point, 6);
        chk("sat_both", bus_sat.point, 4);
        step(11);
        pulse(1);
        chk("final_wrap_tick", bus.sec_tick, 1);
        chk("final_wrap_time", bus.timeNum, 1);
        step(1);
        chk("final_hit_point", bus.point, 7);
        chk("final_hit_state", bus.gameState, 2);
        chk("final_hit_sat", bus_sat.point, 4);
        pulse(1);
        pulse(1);
        step(1);
        chk("over_frozen", bus.point, 7);
        chk("over_state_held", bus.gameState, 2);
        game_over_score(7, 4);

        // Start held for 50 cycles: one transition only.
        bus.start_btn = 1'b1;
        step(3);
        chk("held_start_once", bus.gameState, 0);
        chk("held_start_time", bus.timeNum, 3);
        chk("held_start_point", bus.point, 0);
        step(47);
        chk("held_start_stays", bus.gameState, 0);
        bus.start_btn = 1'b0;
        step(1);
        $display("start held 50 cycles: state %0d", bus.gameState);

        // Game 4: low score must not lower hiscore.
        pulse(0);
        step(1);
        pulse(1);
        step(1);
        chk("game4_point", bus.point, 1);
        step(27);
        chk("game4_over", bus.gameState, 2);
        game_over_score(1, 1);

        // Game 5: reset mid-game.
        pulse(0);
        step(1);
        pulse(0);
        step(1);
        pulse(1);
        step(1);
        chk("game5_point", bus.point, 1);
        step(5);
        rst = 1'b1;
        step(1);
        exp_hi = 0;
        exp_hi_sat = 0;
        chk("midrst_state", bus.gameState, 0);
        chk("midrst_time", bus.timeNum, 3);
        chk("midrst_point", bus.point, 0);
        chk("midrst_tick", bus.sec_tick, 0);
        chk("midrst_hiscore", bus.hiscore, exp_hi);
        chk("midrst_hiscore_sat", bus_sat.hiscore, exp_hi_sat);
        rst = 1'b0;
        step(3);
        chk("post_rst_idle", bus.gameState, 0);
        $display("reset mid-game done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
